decay_tone_sequencer: RTL and testbench

Parametrised successor to the fixed two-pass game-over sound player. It plays a PWM square tone whose duty cycle decays geometrically stage by stage, repeated a configurable number of passes. Duty is computed arithmetically (shift-subtract) rather than from a fixed table. Adds retrigger mode, abort, mute, busy/done status and stage visibility. It sits between game-event logic (jump, score, game-over pulses) and the audio pin mixer; one instance is used per sound effect.

---
 rtl/snd_pkg.sv | 25 ++
 rtl/pwm_period_counter.sv | 33 +++
 rtl/decay_tone_sequencer.sv | 141 ++++++++++++++
 tb/tb_decay_tone_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared sound-effect definitions used by the tone players.
//   snd_state_t : sequencer state (IDLE, PLAY, DONE)
//   CLK_HZ      : default system clock the PERIOD defaults are derived from
//   duty_decay  : one geometric decay step with a floor clamp
package snd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } snd_state_t;

    localparam int unsigned CLK_HZ = 50_000_000;

    // duty - (duty >> shift) cannot underflow since the shifted term is
    // strictly smaller than duty for shift >= 1 and duty >= 1.
    function automatic logic [31:0] duty_decay(input logic [31:0] duty,
                                               input int unsigned shift,
                                               input logic [31:0] flr);
        logic [31:0] d;
        d = duty - (duty >> shift);
        return (d < flr) ? flr : d;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter and PWM comparator for one tone.
//   clk, rst  : clock, synchronous active-high reset
//   adv       : count onward this cycle; when low the counter returns to 0
//   duty_nxt  : duty value that will be in force next cycle
//   wrap      : counter is on the last cycle of the period
//   pwm_nxt   : raw PWM level for next cycle (next counter < next duty)
module pwm_period_counter #(
    parameter int unsigned PERIOD = 200000,
    parameter int unsigned CW     = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [CW-1:0] duty_nxt,
    output logic          wrap,
    output logic          pwm_nxt
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign wrap    = (cnt == CW'(PERIOD - 1));
    assign cnt_nxt = (adv && !wrap) ? cnt + 1'b1 : '0;
    // Comparing the next counter against the next duty lets the caller
    // register the tone bit in step with the counter itself.
    assign pwm_nxt = (cnt_nxt < duty_nxt);

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

endmodule

// File: rtl/decay_tone_sequencer.sv
// PWM square-tone player whose duty decays geometrically per stage,
// swept REPEATS times.
//   clk, rst  : clock, synchronous active-high reset
//   trigger   : start pulse (restarts during playback when RETRIGGER=1)
//   stop      : abort to IDLE, no done pulse; beats trigger
//   mute      : gates wave_out only
//   wave_out  : registered tone output
//   busy      : high while playing
//   done      : one-cycle pulse on natural completion
//   stage_idx : stage within the current pass
//   rep_idx   : current pass
module decay_tone_sequencer
    import snd_pkg::*;
#(
    parameter int unsigned PERIOD      = 200000,
    parameter int unsigned STAGES      = 16,
    parameter int unsigned REPEATS     = 2,
    parameter int unsigned DUTY_START  = 37878,
    parameter int unsigned DECAY_SHIFT = 3,
    parameter int unsigned MIN_DUTY    = 1,
    parameter bit          RETRIGGER   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    input  logic stop,
    input  logic mute,
    output logic wave_out,
    output logic busy,
    output logic done,
    output logic [((STAGES  > 1) ? $clog2(STAGES)  : 1)-1:0] stage_idx,
    output logic [((REPEATS > 1) ? $clog2(REPEATS) : 1)-1:0] rep_idx
);

    // One extra bit of headroom so duty == PERIOD still fits when PERIOD
    // is a power of two.
    localparam int unsigned CW = $clog2(PERIOD + 1);
    localparam int unsigned SW = (STAGES  > 1) ? $clog2(STAGES)  : 1;
    localparam int unsigned RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    localparam logic [CW-1:0] DUTY_INIT  = CW'(DUTY_START);
    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
    localparam logic [RW-1:0] LAST_REP   = RW'(REPEATS - 1);

    if (PERIOD < 2 || STAGES < 1 || REPEATS < 1 ||
        DUTY_START < 1 || DUTY_START > PERIOD ||
        DECAY_SHIFT < 1 || MIN_DUTY < 1 || MIN_DUTY > DUTY_START) begin : g_param_chk
        $error("decay_tone_sequencer: illegal parameter set");
    end

    snd_state_t    state, state_nxt;
    logic [SW-1:0] stage_nxt;
    logic [RW-1:0] rep_nxt;
    logic [CW-1:0] duty, duty_nxt;
    logic          adv, start, wrap, pwm_nxt;

    pwm_period_counter #(
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .duty_nxt (duty_nxt),
        .wrap     (wrap),
        .pwm_nxt  (pwm_nxt)
    );

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_idx;
        rep_nxt   = rep_idx;
        duty_nxt  = duty;
        adv       = 1'b0;
        // DONE accepts a trigger as a back-to-back start.
        start     = trigger && ((state != PLAY) || RETRIGGER);

        if (stop) begin
            state_nxt = IDLE;
            stage_nxt = '0;
            rep_nxt   = '0;
            duty_nxt  = DUTY_INIT;
        end else if (start) begin
            // adv stays low so the counter restarts at 0.
            state_nxt = PLAY;
            stage_nxt = '0;
            rep_nxt   = '0;
            duty_nxt  = DUTY_INIT;
        end else begin
            case (state)
                PLAY: begin
                    adv = 1'b1;
                    if (wrap) begin
                        if (stage_idx == LAST_STAGE) begin
                            stage_nxt = '0;
                            duty_nxt  = DUTY_INIT;
                            if (rep_idx == LAST_REP) begin
                                state_nxt = DONE;
                                rep_nxt   = '0;
                            end else begin
                                rep_nxt = rep_idx + 1'b1;
                            end
                        end else begin
                            stage_nxt = stage_idx + 1'b1;
                            duty_nxt  = CW'(duty_decay(32'(duty), DECAY_SHIFT,
                                                       32'(MIN_DUTY)));
                        end
                    end
                end
                default: begin
                    // IDLE holds, DONE falls back to IDLE after one cycle.
                    state_nxt = IDLE;
                    stage_nxt = '0;
                    rep_nxt   = '0;
                    duty_nxt  = DUTY_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage_idx <= '0;
            rep_idx   <= '0;
            duty      <= DUTY_INIT;
            wave_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            stage_idx <= stage_nxt;
            rep_idx   <= rep_nxt;
            duty      <= duty_nxt;
            wave_out  <= (state_nxt == PLAY) && pwm_nxt && !mute;
            busy      <= (state_nxt == PLAY);
            done      <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_decay_tone_sequencer.sv
// Four players share one stimulus stream:
//   dut0 DUTY_START=16 MIN_DUTY=2 RETRIGGER=1  (duties 16,12,9,7)
//   dut1 DUTY_START=4  MIN_DUTY=3 RETRIGGER=1  (duties 4,3,3,3)
//   dut2 DUTY_START=20 MIN_DUTY=2 RETRIGGER=1  (first period fully high)
//   dut3 DUTY_START=16 MIN_DUTY=2 RETRIGGER=0
// The model tracks only "playing / done / idle" plus elapsed cycles since
// start, and derives stage, pass and tone level from that elapsed time.
module tb_decay_tone_sequencer;

    localparam int ND = 4;
    localparam int P  = 20;
    localparam int S  = 4;
    localparam int R  = 2;
    localparam int SH = 2;
    localparam int TOTAL = S * R * P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trigger = 1'b0;
    logic stop = 1'b0;
    logic mute = 1'b0;

    logic [ND-1:0] wave, busy, done;
    logic [1:0]    stage [ND];
    logic [0:0]    rep   [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        decay_tone_sequencer #(
            .PERIOD      (P),
            .STAGES      (S),
            .REPEATS     (R),
            .DUTY_START  (g == 1 ? 4 : (g == 2 ? 20 : 16)),
            .DECAY_SHIFT (SH),
            .MIN_DUTY    (g == 1 ? 3 : 2),
            .RETRIGGER   (g != 3)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .trigger   (trigger),
            .stop      (stop),
            .mute      (mute),
            .wave_out  (wave[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .stage_idx (stage[g]),
            .rep_idx   (rep[g])
        );
    end

    typedef struct {
        logic [ND-1:0] wave, busy, done;
        int            stg [ND];
        int            rp  [ND];
    } exp_t;

    exp_t q[$];
    int   duty_t [ND][S];
    int   ph [ND];   // 0 idle, 1 playing, 2 done cycle
    int   t  [ND];   // cycles elapsed since start
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_no = 0;

    function automatic int ds_of(int d);  return d == 1 ? 4 : (d == 2 ? 20 : 16); endfunction
    function automatic int min_of(int d); return d == 1 ? 3 : 2; endfunction
    function automatic bit rt_of(int d);  return d != 3; endfunction

    task automatic model_step();
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            if (rst || stop)                             ph[d] = 0;
            else if (trigger && (ph[d] != 1 || rt_of(d))) begin ph[d] = 1; t[d] = 0; end
            else if (ph[d] == 1) begin
                t[d] = t[d] + 1;
                if (t[d] == TOTAL) ph[d] = 2;
            end else                                     ph[d] = 0;

            e.busy[d] = (ph[d] == 1);
            e.done[d] = (ph[d] == 2);
            if (ph[d] == 1) begin
                e.stg[d]  = (t[d] / P) % S;
                e.rp[d]   = (t[d] / P) / S;
                e.wave[d] = ((t[d] % P) < duty_t[d][e.stg[d]]) && !mute;
            end else begin
                e.stg[d]  = 0;
                e.rp[d]   = 0;
                e.wave[d] = 1'b0;
            end
        end
        q.push_back(e);
    endtask

    task automatic chk(string nm, int d, int act, int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc_no, act, exp_v);
        end
    endtask

    // Reference model: sample inputs at each rising edge.
    initial begin
        for (int d = 0; d < ND; d++) begin
            int v;
            v = ds_of(d);
            for (int k = 0; k < S; k++) begin
                duty_t[d][k] = v;
                v = v - (v >> SH);
                if (v < min_of(d)) v = min_of(d);
            end
            ph[d] = 0;
            t[d]  = 0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the scoreboard.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            cyc_no++;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc_no);
            end else begin
                e = q.pop_front();
                for (int d = 0; d < ND; d++) begin
                    chk("wave_out",  d, int'(wave[d]),  int'(e.wave[d]));
                    chk("busy",      d, int'(busy[d]),  int'(e.busy[d]));
                    chk("done",      d, int'(done[d]),  int'(e.done[d]));
                    chk("stage_idx", d, int'(stage[d]), e.stg[d]);
                    chk("rep_idx",   d, int'(rep[d]),   e.rp[d]);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(5);

        // Full sweep, both passes, done pulse, back to idle.
        pulse_trigger();
        cyc(TOTAL + 5);

        // Retrigger in stage 2 of pass 0.
        pulse_trigger();
        cyc(2 * P + 5);
        pulse_trigger();
        cyc(TOTAL + 5);

        // Stop mid-pass, stop held as a level, stop together with trigger.
        pulse_trigger();
        cyc(30);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(10);
        pulse_trigger();
        cyc(7);
        stop = 1'b1;
        cyc(4);
        stop = 1'b0;
        cyc(3);
        stop = 1'b1;
        trigger = 1'b1;
        cyc(1);
        stop = 1'b0;
        trigger = 1'b0;
        cyc(5);

        // Mute through pass 1.
        pulse_trigger();
        cyc(S * P - 1);
        mute = 1'b1;
        cyc(S * P + 3);
        mute = 1'b0;
        cyc(5);

        // Reset mid-playback.
        pulse_trigger();
        cyc(50);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(5);

        // Trigger exactly in the DONE cycle: back-to-back start.
        pulse_trigger();
        cyc(TOTAL);
        pulse_trigger();
        cyc(TOTAL + 5);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            trigger = ($urandom_range(0, 39) == 0);
            stop    = ($urandom_range(0, 149) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) mute = ~mute;
            cyc(1);
        end
        trigger = 1'b0;
        stop    = 1'b0;
        rst     = 1'b0;
        mute    = 1'b0;
        cyc(TOTAL + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
